// File: rtl/mole_spawn_ctrl.sv
// Whack-a-mole spawn/lifetime controller: tick prescaler, LFSR hole picker, per-hole timers.
// Optional MOLE_SPEEDUP_EN: lifetime shrinks by one every 4th hit, floored at 2.
module mole_spawn_ctrl #(
    parameter int unsigned TICK_DIV  = 10_000_000,
    parameter int unsigned MOLE_LIFE = 8,
    parameter int unsigned SPAWN_GAP = 4,
    parameter int unsigned MAX_MOLES = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] whack_pos,
    output logic [8:0] map,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic       escape_pulse
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]   pre_q, pre_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [3:0]      spawn_q, spawn_d;
    logic [8:0][3:0] cnt_q, cnt_d;
    logic [8:0]      map_q, map_d;
    logic            hit_q, miss_q, esc_q;
    logic            hit_d, miss_d, esc_d;

    logic       tick, attempt, do_spawn, found;
    logic [3:0] life, start, probe;
    logic [4:0] sum;
    logic [8:0] whack_vec, spawn_vec, expire;

    always_comb begin
        tick     = enable && (pre_q == PW'(TICK_DIV - 1));
        pre_d    = (!enable || tick) ? '0 : pre_q + 1'b1;
        lfsr_d   = {lfsr_q[14:0],
                    lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        attempt  = tick && (spawn_q == 4'(SPAWN_GAP - 1));
        do_spawn = attempt && ($countones(map_q) < MAX_MOLES);
        if (!enable || attempt)
            spawn_d = '0;
        else if (tick)
            spawn_d = spawn_q + 1'b1;
        else
            spawn_d = spawn_q;
    end

    // First free hole at or above the random start, wrapping 8 -> 0.
    always_comb begin
        start     = 4'(lfsr_q[7:0] % 8'd9);
        spawn_vec = '0;
        found     = 1'b0;
        sum       = '0;
        probe     = '0;
        for (int k = 0; k < 9; k++) begin
            sum   = {1'b0, start} + 5'(k);
            probe = (sum > 5'd8) ? 4'(sum - 5'd9) : sum[3:0];
            if (!found && !map_q[probe]) begin
                spawn_vec[probe] = 1'b1;
                found            = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        map_d  = map_q;
        expire = '0;
        for (int i = 0; i < 9; i++) begin
            whack_vec[i] = enable && (whack_pos == 4'(i + 1));
            if (tick && cnt_q[i] != 4'd0) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
                if (cnt_q[i] == 4'd1) begin
                    map_d[i]  = 1'b0;
                    expire[i] = 1'b1;
                end
            end
            if (whack_vec[i] && map_q[i]) begin
                cnt_d[i] = '0;
                map_d[i] = 1'b0;
            end
            if (do_spawn && spawn_vec[i]) begin
                cnt_d[i] = life;
                map_d[i] = 1'b1;
            end
        end
        if (!enable) begin
            cnt_d = '0;
            map_d = '0;
        end
        hit_d  = |(whack_vec & map_q);
        miss_d = |(whack_vec & ~map_q);
        // A hole whacked in its expiry cycle is a hit, not an escape.
        esc_d  = |(expire & ~whack_vec);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            spawn_q <= '0;
            cnt_q   <= '0;
            map_q   <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            esc_q   <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            lfsr_q  <= lfsr_d;
            spawn_q <= spawn_d;
            cnt_q   <= cnt_d;
            map_q   <= map_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            esc_q   <= esc_d;
        end
    end

`ifdef MOLE_SPEEDUP_EN
    logic [3:0] hits_q, hits_d, life_q, life_d;

    always_comb begin
        hits_d = hits_q;
        life_d = life_q;
        if (hit_d) begin
            hits_d = hits_q + 1'b1;
            if (hits_q[1:0] == 2'd3 && life_q > 4'd2)
                life_d = life_q - 1'b1;
        end
        if (!enable)
            life_d = 4'(MOLE_LIFE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hits_q <= '0;
            life_q <= 4'(MOLE_LIFE);
        end else begin
            hits_q <= hits_d;
            life_q <= life_d;
        end
    end

    assign life = life_q;
`else
    assign life = 4'(MOLE_LIFE);
`endif

    assign map          = map_q;
    assign hit_pulse    = hit_q;
    assign miss_pulse   = miss_q;
    assign escape_pulse = esc_q;

endmodule
